// File: rtl/nios_sd_clkgen.sv
// -----------------------------------------------------------------------------
// nios_sd_clkgen
// Avalon-MM programmable SD clock generator. The block either holds sd_clk at a
// software-written static level, or produces a burst of N clock pulses whose
// high and low phases each last DIV+1 system clocks. The end of a burst sets a
// sticky done flag, which can raise an interrupt.
//
// Register map (word address):
//   0 LEVEL  W: writedata[0] -> sd_clk (idle only)     R: {31'b0, sd_clk}
//   1 DIV    W: half-period divisor (idle only)        R: zero-extended DIV
//   2 BURST  W: start N-pulse burst (idle, N != 0)     R: remaining pulses
//   3 CTRL   W: bit2 irq_en, bit1 W1C done, bit4 abort R: {irq_en, done, busy}
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata      Avalon-MM write side
//   readdata                combinational read data (latency 0)
//   sd_clk                  registered SD clock
//   irq                     registered done AND irq_en
// -----------------------------------------------------------------------------
module nios_sd_clkgen #(
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 16,
    parameter int RESET_DIV = 124
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sd_clk,
    output logic        irq
);

    localparam logic [1:0] ADDR_LEVEL = 2'd0;
    localparam logic [1:0] ADDR_DIV   = 2'd1;
    localparam logic [1:0] ADDR_BURST = 2'd2;
    localparam logic [1:0] ADDR_CTRL  = 2'd3;

    logic [DIV_WIDTH-1:0] div_r,  div_s;
    logic [DIV_WIDTH-1:0] hcnt_r, hcnt_s;
    logic [CNT_WIDTH-1:0] rem_r,  rem_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic                 irq_en_r, irq_en_s;
    logic                 sd_clk_r, sd_clk_s;
    logic                 irq_r, irq_s;

    logic                 wr_s;
    logic [CNT_WIDTH-1:0] burst_n_s;

    assign wr_s      = chipselect & ~write_n;
    assign burst_n_s = writedata[CNT_WIDTH-1:0];

    // Next-state logic for all registers.
    always_comb begin
        div_s    = div_r;
        hcnt_s   = hcnt_r;
        rem_s    = rem_r;
        busy_s   = busy_r;
        done_s   = done_r;
        irq_en_s = irq_en_r;
        sd_clk_s = sd_clk_r;

        // CTRL irq_en and done-clear apply whether busy or idle. The burst-end
        // set below is evaluated afterwards so that it wins over a clear.
        if (wr_s && (address == ADDR_CTRL)) begin
            irq_en_s = writedata[2];
            if (writedata[1]) begin
                done_s = 1'b0;
            end else begin
                done_s = done_r;
            end
        end else begin
            irq_en_s = irq_en_r;
        end

        if (busy_r) begin
            if (wr_s && (address == ADDR_CTRL) && writedata[4]) begin
                // Abort: drop the burst immediately, done is left alone.
                busy_s   = 1'b0;
                rem_s    = {CNT_WIDTH{1'b0}};
                sd_clk_s = 1'b0;
                hcnt_s   = {DIV_WIDTH{1'b0}};
            end else if (hcnt_r == {DIV_WIDTH{1'b0}}) begin
                // Phase boundary; reload instead of wrapping so DIV=all-ones works.
                hcnt_s = div_r;
                if (sd_clk_r) begin
                    sd_clk_s = 1'b0;
                    if (rem_r == {CNT_WIDTH{1'b0}}) begin
                        busy_s = 1'b0;
                        done_s = 1'b1;
                        hcnt_s = {DIV_WIDTH{1'b0}};
                    end else begin
                        busy_s = 1'b1;
                    end
                end else begin
                    sd_clk_s = 1'b1;
                    rem_s    = rem_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end else begin
                hcnt_s = hcnt_r - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
            end
        end else if (wr_s) begin
            case (address)
                ADDR_LEVEL: sd_clk_s = writedata[0];
                ADDR_DIV:   div_s    = writedata[DIV_WIDTH-1:0];
                ADDR_BURST: begin
                    if (burst_n_s != {CNT_WIDTH{1'b0}}) begin
                        busy_s   = 1'b1;
                        rem_s    = burst_n_s;
                        sd_clk_s = 1'b0;
                        hcnt_s   = div_r;
                    end else begin
                        busy_s   = 1'b0;
                    end
                end
                ADDR_CTRL:  busy_s = 1'b0;
                default:    busy_s = 1'b0;
            endcase
        end else begin
            busy_s = 1'b0;
        end

        irq_s = done_s & irq_en_s;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_r    <= DIV_WIDTH'(RESET_DIV);
            hcnt_r   <= {DIV_WIDTH{1'b0}};
            rem_r    <= {CNT_WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            irq_en_r <= 1'b0;
            sd_clk_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            div_r    <= div_s;
            hcnt_r   <= hcnt_s;
            rem_r    <= rem_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            irq_en_r <= irq_en_s;
            sd_clk_r <= sd_clk_s;
            irq_r    <= irq_s;
        end
    end

    // Read mux, combinational from the address with no side effects.
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_LEVEL: readdata = {31'd0, sd_clk_r};
            ADDR_DIV:   readdata = 32'(div_r);
            ADDR_BURST: readdata = 32'(rem_r);
            ADDR_CTRL:  readdata = {29'd0, irq_en_r, done_r, busy_r};
            default:    readdata = 32'd0;
        endcase
    end

    assign sd_clk = sd_clk_r;
    assign irq    = irq_r;

endmodule

// File: tb/tb_nios_sd_clkgen.sv
// -----------------------------------------------------------------------------
// Self-checking bench for nios_sd_clkgen. A burst is predicted from the cycle
// index k after the accepting edge: sd_clk = (k / (DIV+1)) mod 2, pulses seen
// so far = (k / (DIV+1) + 1) / 2, and the burst ends at k = 2*N*(DIV+1).
// -----------------------------------------------------------------------------
module tb_nios_sd_clkgen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        sd_clk;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int m_div    = 124;
    bit m_done   = 1'b0;
    bit m_irq_en = 1'b0;

    nios_sd_clkgen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .sd_clk     (sd_clk),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        drive_wr(a, d);
        tick();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        rd(2'd1, v); n_cmp++;
        if (v !== 32'd124) begin n_err++; $display("FAIL reset_div: got %0d want 124", v); end
        rd(2'd3, v); n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL reset_ctrl: got %0h want 0", v); end
        rd(2'd2, v); n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL reset_burst: got %0d want 0", v); end
        n_cmp++;
        if (sd_clk !== 1'b0 || irq !== 1'b0) begin
            n_err++; $display("FAIL reset_outs: sd_clk=%b irq=%b want 0 0", sd_clk, irq);
        end
        // First edge after release must accept a write.
        wr(2'd0, 32'd1); n_cmp++;
        if (sd_clk !== 1'b1) begin n_err++; $display("FAIL first_write: sd_clk=%b want 1", sd_clk); end
        wr(2'd0, 32'd0); n_cmp++;
        if (sd_clk !== 1'b0) begin n_err++; $display("FAIL level0: sd_clk=%b want 0", sd_clk); end
    endtask

    // Runs one burst and checks every cycle against the model; with inject set,
    // random LEVEL/DIV/BURST writes are thrown at it and must be ignored.
    task automatic run_burst(input int d, input int n, input bit inject, output int rises);
        logic [31:0] c, r, v;
        int t, exp_sd, exp_rem;
        logic prev;
        bit done_before;
        rises = 0;
        done_before = m_done;
        wr(2'd1, 32'(d));
        m_div = d;
        wr(2'd2, 32'(n));
        prev = sd_clk;
        t = 2 * n * (d + 1);
        for (int k = 1; k <= t; k++) begin
            if (inject && $urandom_range(0, 2) == 0)
                drive_wr(2'($urandom_range(0, 2)), $urandom);
            tick();
            exp_sd  = (k / (d + 1)) % 2;
            exp_rem = n - ((k / (d + 1)) + 1) / 2;
            if (k == t) m_done = 1'b1;
            rd(2'd3, c);
            rd(2'd2, r);
            if (prev == 1'b0 && sd_clk == 1'b1) rises++;
            prev = sd_clk;
            n_cmp++;
            if (sd_clk !== 1'(exp_sd) || c[2:0] !== {m_irq_en, (k == t) ? 1'b1 : done_before, (k < t)}
                || r !== 32'(exp_rem) || irq !== (m_done & m_irq_en)) begin
                n_err++;
                $display("FAIL burst_cycle d=%0d n=%0d k=%0d: sd=%b ctrl=%0h rem=%0d irq=%b want sd=%0d busy=%0d rem=%0d",
                         d, n, k, sd_clk, c[2:0], r, irq, exp_sd, (k < t), exp_rem);
            end
        end
        rd(2'd1, v); n_cmp++;
        if (v !== 32'(d)) begin n_err++; $display("FAIL div_kept: got %0d want %0d", v, d); end
    endtask

    task automatic test_burst_basic();
        int rises;
        wr(2'd3, 32'h2); m_done = 1'b0; m_irq_en = 1'b0;
        run_burst(1, 3, 1'b0, rises);
        n_cmp++;
        if (rises !== 3) begin n_err++; $display("FAIL basic_rises: got %0d want 3", rises); end
    endtask

    task automatic test_ignored_writes();
        int rises;
        logic [31:0] v;
        wr(2'd3, 32'h2); m_done = 1'b0;
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd8);
        drive_wr(2'd0, 32'd1); tick();
        drive_wr(2'd1, 32'd5); tick();
        drive_wr(2'd2, 32'd2); tick();
        rises = (sd_clk === 1'b1) ? 2 : 1;
        for (int k = 4; k <= 16; k++) begin
            tick();
            n_cmp++;
            if (sd_clk !== 1'(k % 2)) begin
                n_err++; $display("FAIL ignored_wr k=%0d: sd=%b want %0d", k, sd_clk, k % 2);
            end
            if (sd_clk === 1'b1) rises++;
        end
        rd(2'd3, v); n_cmp++;
        if (rises !== 8 || v[1:0] !== 2'b10) begin
            n_err++; $display("FAIL ignored_end: rises=%0d ctrl=%0h want 8 and done", rises, v);
        end
        rd(2'd1, v); n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL ignored_div: got %0d want 0", v); end
        m_done = 1'b1; m_div = 0;
    endtask

    task automatic test_random_bursts();
        int rises;
        for (int i = 0; i < 15; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                m_irq_en = 1'($urandom_range(0, 1));
                wr(2'd3, {29'd0, m_irq_en, 2'b10});
                m_done = 1'b0;
            end
            run_burst($urandom_range(0, 4), $urandom_range(1, 5), 1'b1, rises);
        end
    endtask

    task automatic test_irq();
        logic [31:0] v;
        wr(2'd3, 32'h6); m_done = 1'b0; m_irq_en = 1'b1;
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_cleared: irq=%b want 0", irq); end
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd1);
        tick(); n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early: irq=%b want 0", irq); end
        tick(); n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rise: irq=%b want 1", irq); end
        wr(2'd3, 32'h6);
        rd(2'd3, v); n_cmp++;
        if (irq !== 1'b0 || v !== 32'h4) begin
            n_err++; $display("FAIL irq_fall: irq=%b ctrl=%0h want 0 and 4", irq, v);
        end
        m_done = 1'b0;
    endtask

    task automatic test_abort();
        logic [31:0] c, r;
        wr(2'd3, 32'h2); m_done = 1'b0; m_irq_en = 1'b0;
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd8);
        repeat (5) tick();
        rd(2'd2, r); n_cmp++;
        if (r !== 32'd5) begin n_err++; $display("FAIL abort_pre_rem: got %0d want 5", r); end
        wr(2'd3, 32'h10);
        rd(2'd3, c); rd(2'd2, r); n_cmp++;
        if (sd_clk !== 1'b0 || c !== 32'd0 || r !== 32'd0) begin
            n_err++; $display("FAIL abort: sd=%b ctrl=%0h rem=%0d want 0 0 0", sd_clk, c, r);
        end
        repeat (3) tick();
        n_cmp++;
        if (sd_clk !== 1'b0) begin n_err++; $display("FAIL abort_quiet: sd=%b want 0", sd_clk); end
        // Abort while idle changes nothing.
        wr(2'd0, 32'd1);
        wr(2'd3, 32'h10);
        rd(2'd3, c); n_cmp++;
        if (sd_clk !== 1'b1 || c !== 32'd0) begin
            n_err++; $display("FAIL abort_idle: sd=%b ctrl=%0h want 1 0", sd_clk, c);
        end
        wr(2'd0, 32'd0);
    endtask

    task automatic test_set_wins();
        logic [31:0] c;
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd1);
        tick();
        drive_wr(2'd3, 32'h2);
        tick();
        rd(2'd3, c); n_cmp++;
        if (c !== 32'h2) begin n_err++; $display("FAIL set_wins: ctrl=%0h want 2", c); end
        m_done = 1'b1;
    endtask

    task automatic test_abort_irq_en();
        logic [31:0] c, r;
        wr(2'd1, 32'd2);
        wr(2'd2, 32'd4);
        repeat (4) tick();
        wr(2'd3, 32'h14);
        m_irq_en = 1'b1;
        rd(2'd3, c); rd(2'd2, r); n_cmp++;
        if (c !== 32'h6 || sd_clk !== 1'b0 || irq !== 1'b1 || r !== 32'd0) begin
            n_err++; $display("FAIL abort_irq_en: ctrl=%0h sd=%b irq=%b rem=%0d want 6 0 1 0", c, sd_clk, irq, r);
        end
        wr(2'd3, 32'h2); m_done = 1'b0; m_irq_en = 1'b0;
    endtask

    task automatic test_div_max();
        logic [31:0] v, c;
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, v); n_cmp++;
        if (v !== 32'h0000_FFFF) begin n_err++; $display("FAIL div_max: got %0h want ffff", v); end
        wr(2'd2, 32'd1);
        repeat (20) tick();
        rd(2'd3, c); rd(2'd2, v); n_cmp++;
        if (sd_clk !== 1'b0 || c[0] !== 1'b1 || v !== 32'd1) begin
            n_err++; $display("FAIL div_max_run: sd=%b busy=%b rem=%0d want 0 1 1", sd_clk, c[0], v);
        end
        wr(2'd3, 32'h10);
    endtask

    task automatic test_reset_midburst();
        logic [31:0] v;
        wr(2'd1, 32'd1);
        wr(2'd2, 32'd4);
        repeat (3) tick();
        n_cmp++;
        if (sd_clk !== 1'b1) begin n_err++; $display("FAIL midburst_high: sd=%b want 1", sd_clk); end
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (sd_clk !== 1'b0 || irq !== 1'b0) begin
            n_err++; $display("FAIL async_reset: sd=%b irq=%b want 0 0", sd_clk, irq);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_div = 124; m_done = 1'b0; m_irq_en = 1'b0;
        rd(2'd3, v); n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL post_reset_ctrl: got %0h want 0", v); end
        rd(2'd1, v); n_cmp++;
        if (v !== 32'd124) begin n_err++; $display("FAIL post_reset_div: got %0d want 124", v); end
        repeat (3) tick();
        n_cmp++;
        if (sd_clk !== 1'b0) begin n_err++; $display("FAIL post_reset_quiet: sd=%b want 0", sd_clk); end
        wr(2'd0, 32'd1);
        n_cmp++;
        if (sd_clk !== 1'b1) begin n_err++; $display("FAIL post_reset_level: sd=%b want 1", sd_clk); end
    endtask

    initial begin
        test_reset();
        test_burst_basic();
        test_ignored_writes();
        test_random_bursts();
        test_irq();
        test_abort();
        test_set_wins();
        test_abort_irq_en();
        test_div_max();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
